// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, funct codes,
// ALU operation codes, datapath mux encodings and the controller state encoding.
package multicycle_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_IEXEC    = 4'd9,
    S_IWB      = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // ALUOp: the controller's request to the ALU decoder
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [2:0] SRCB_B       = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_SIMM    = 3'b010;
  localparam logic [2:0] SRCB_SIMM_SH = 3'b011;
  localparam logic [2:0] SRCB_ZIMM    = 3'b100;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> datapath bundle. The master is the control unit, the slave is
// the datapath (instruction register, ALU flags, memory and the muxes/enables).
interface multicycle_control_fsm_if #(
  parameter int OPCODE_WIDTH = 6,
  parameter int FUNCT_WIDTH  = 6,
  parameter int ALU_OP_WIDTH = 4,
  parameter int CNT_WIDTH    = 32
);
  // Memory handshake: MemReady high in a cycle means the access presented in
  // that cycle (fetch, load or store) completes at the next rising edge;
  // while it is low the controller holds its state and its request outputs.
  logic [OPCODE_WIDTH-1:0] Opcode;
  logic [FUNCT_WIDTH-1:0]  Funct;
  logic                    Zero;
  logic                    MemReady;

  logic                    IorD;
  logic [1:0]              ALUSrcA;
  logic [2:0]              ALUSrcB;
  logic [1:0]              RegDst;
  logic [1:0]              MemtoReg;
  logic [1:0]              PCSrc;
  logic [1:0]              Branch;
  logic                    IRWrite;
  logic                    MemWrite;
  logic                    PCWrite;
  logic                    RegWrite;
  logic                    PCEn;
  logic [ALU_OP_WIDTH-1:0] ALUControl;
  logic                    IllegalInstr;
  logic [CNT_WIDTH-1:0]    InstrCount;

  modport master (
    input  Opcode, Funct, Zero, MemReady,
    output IorD, ALUSrcA, ALUSrcB, RegDst, MemtoReg, PCSrc, Branch,
           IRWrite, MemWrite, PCWrite, RegWrite, PCEn, ALUControl,
           IllegalInstr, InstrCount
  );

  modport slave (
    output Opcode, Funct, Zero, MemReady,
    input  IorD, ALUSrcA, ALUSrcB, RegDst, MemtoReg, PCSrc, Branch,
           IRWrite, MemWrite, PCWrite, RegWrite, PCEn, ALUControl,
           IllegalInstr, InstrCount
  );
endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU decoder: turns the controller's ALUOp request (and Funct for R-type)
// into the ALUControl code driven to the ALU.
module mc_alu_decoder
  import multicycle_control_fsm_pkg::*;
#(
  parameter int FUNCT_WIDTH  = 6,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic [2:0]              alu_op,
  input  logic [FUNCT_WIDTH-1:0]  funct,
  output logic [ALU_OP_WIDTH-1:0] alu_control
);
  logic [5:0] fn;
  logic [3:0] code;

  assign fn = 6'(funct);

  always_comb begin
    code = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_AND: code = ALU_AND;
      ALUOP_OR:  code = ALU_OR;
      ALUOP_SLT: code = ALU_SLT;
      ALUOP_FUNCT: begin
        // unrecognised funct codes fall back to add
        case (fn)
          FN_SUB, FN_SUBU: code = ALU_SUB;
          FN_AND:          code = ALU_AND;
          FN_OR:           code = ALU_OR;
          FN_XOR:          code = ALU_XOR;
          FN_NOR:          code = ALU_NOR;
          FN_SLT:          code = ALU_SLT;
          default:         code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_OP_WIDTH'(code);
endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore-style main controller for the multicycle MIPS datapath with a memory
// ready handshake, JAL/BNE support, an illegal-opcode trap and a retire counter.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int FUNCT_WIDTH  = 6,
  parameter int ALU_OP_WIDTH = 4,
  parameter int MEM_WAIT_EN  = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_control_fsm_if.master bus,
  output state_t                   state_dbg
);
  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [5:0]              op;
  logic                    mem_rdy;

  logic       iord, irw, mw, pcw, rw;
  logic [1:0] srca, regdst, m2r, pcsrc, branch;
  logic [2:0] srcb, alu_op;

  assign opcode  = bus.Opcode;
  assign op      = 6'(opcode);
  assign mem_rdy = (MEM_WAIT_EN != 0) ? bus.MemReady : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // an instruction retires on every return to FETCH
      if (state_d == S_FETCH && state_q != S_FETCH)
        cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    iord    = 1'b0;
    srca    = 2'd0;
    srcb    = SRCB_B;
    regdst  = 2'd0;
    m2r     = 2'd0;
    pcsrc   = 2'd0;
    branch  = BR_NONE;
    irw     = 1'b0;
    mw      = 1'b0;
    pcw     = 1'b0;
    rw      = 1'b0;
    alu_op  = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        srcb = SRCB_FOUR;
        irw  = mem_rdy;
        pcw  = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        srcb = SRCB_SIMM_SH;
        case (op)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_RTYPE:                          state_d = S_EXECUTE;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
          OP_J:                              state_d = S_JUMP;
          OP_JAL:                            state_d = S_JAL;
          default:                           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        srca    = 2'd1;
        srcb    = SRCB_SIMM;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        iord = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        iord = 1'b1;
        mw   = 1'b1;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_MEMWB: begin
        m2r     = 2'd1;
        rw      = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECUTE: begin
        srca    = 2'd1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst  = 2'd1;
        rw      = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        srca    = 2'd1;
        alu_op  = ALUOP_SUB;
        pcsrc   = 2'd1;
        branch  = (op == OP_BNE) ? BR_NE : BR_EQ;
        state_d = S_FETCH;
      end
      S_IEXEC: begin
        srca = 2'd1;
        // logical immediates are zero-extended, arithmetic ones sign-extended
        srcb = (op == OP_ANDI || op == OP_ORI) ? SRCB_ZIMM : SRCB_SIMM;
        case (op)
          OP_ANDI: alu_op = ALUOP_AND;
          OP_ORI:  alu_op = ALUOP_OR;
          OP_SLTI: alu_op = ALUOP_SLT;
          default: alu_op = ALUOP_ADD;
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        rw      = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'd2;
        pcw     = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        pcsrc   = 2'd2;
        pcw     = 1'b1;
        regdst  = 2'd2;
        m2r     = 2'd2;
        rw      = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  mc_alu_decoder #(
    .FUNCT_WIDTH  (FUNCT_WIDTH),
    .ALU_OP_WIDTH (ALU_OP_WIDTH)
  ) u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (bus.Funct),
    .alu_control (bus.ALUControl)
  );

  // enables are blocked for as long as rst is high, not just until the edge
  assign bus.IRWrite  = irw & ~rst;
  assign bus.MemWrite = mw & ~rst;
  assign bus.PCWrite  = pcw & ~rst;
  assign bus.RegWrite = rw & ~rst;
  assign bus.PCEn     = ~rst & (pcw | ((branch == BR_EQ) & bus.Zero)
                                    | ((branch == BR_NE) & ~bus.Zero));

  assign bus.IorD         = iord;
  assign bus.ALUSrcA      = srca;
  assign bus.ALUSrcB      = srcb;
  assign bus.RegDst       = regdst;
  assign bus.MemtoReg     = m2r;
  assign bus.PCSrc        = pcsrc;
  assign bus.Branch       = branch;
  assign bus.IllegalInstr = (state_q == S_TRAP);
  assign bus.InstrCount   = cnt_q;
  assign state_dbg        = state_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle expected state, control
// bundle and retire count are queued by the driver and checked by a monitor.
module tb_multicycle_control_fsm;
  localparam int CW = 4;

  localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_A = 4'd2, S_R = 4'd3,
                         S_MWB = 4'd4, S_W = 4'd5, S_E = 4'd6, S_AWB = 4'd7,
                         S_B = 4'd8, S_IE = 4'd9, S_IWB = 4'd10, S_J = 4'd11,
                         S_JAL = 4'd12, S_T = 4'd13;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                         OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_LW = 6'h23, OP_SW = 6'h2B, OP_BAD = 6'h3F;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_XOR = 6'h26,
                         FN_NOR = 6'h27, FN_BAD = 6'h3F;
  localparam logic [3:0] A_AND = 4'h0, A_OR = 4'h1, A_ADD = 4'h2, A_XOR = 4'h3,
                         A_SUB = 4'h6, A_SLT = 4'h7, A_NOR = 4'hC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] state_dbg;

  multicycle_control_fsm_if #(.CNT_WIDTH(CW)) bus ();

  multicycle_control_fsm #(.CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [CW-1:0] cnt_exp = '0;
  logic [23:0] act_ctl;

  assign act_ctl = {bus.IorD, bus.ALUSrcA, bus.ALUSrcB, bus.RegDst, bus.MemtoReg,
                    bus.PCSrc, bus.Branch, bus.IRWrite, bus.MemWrite, bus.PCWrite,
                    bus.RegWrite, bus.PCEn, bus.ALUControl, bus.IllegalInstr};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [31:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk({t, "_state"}, 32'(state_dbg), 32'(e[31:28]));
      chk({t, "_ctl"},   32'(act_ctl),   32'(e[27:4]));
      chk({t, "_cnt"},   32'(bus.InstrCount), 32'(e[3:0]));
    end
  end

  // ---------------- expected control bundles ----------------
  function automatic logic [23:0] pk(input logic iord, input logic [1:0] sa,
      input logic [2:0] sb, input logic [1:0] rd, input logic [1:0] m2r,
      input logic [1:0] pcs, input logic [1:0] br, input logic irw, input logic mw,
      input logic pcw, input logic rw, input logic pcen, input logic [3:0] alu,
      input logic ill);
    return {iord, sa, sb, rd, m2r, pcs, br, irw, mw, pcw, rw, pcen, alu, ill};
  endfunction

  function automatic logic [23:0] o_fetch(input logic r);
    return pk(0, 0, 3'b001, 0, 0, 0, 0, r, 0, r, 0, r, A_ADD, 0);
  endfunction
  function automatic logic [23:0] o_exec(input logic [3:0] a);
    return pk(0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, a, 0);
  endfunction
  function automatic logic [23:0] o_branch(input logic [1:0] br, input logic pcen);
    return pk(0, 1, 3'b000, 0, 0, 1, br, 0, 0, 0, 0, pcen, A_SUB, 0);
  endfunction
  function automatic logic [23:0] o_iexec(input logic [2:0] sb, input logic [3:0] a);
    return pk(0, 1, sb, 0, 0, 0, 0, 0, 0, 0, 0, 0, a, 0);
  endfunction

  localparam logic [23:0] O_DEC   = {1'b0, 2'd0, 3'b011, 18'b0} | {20'b0, A_ADD, 1'b0};
  localparam logic [23:0] O_MADR  = {1'b0, 2'd1, 3'b010, 18'b0} | {20'b0, A_ADD, 1'b0};
  localparam logic [23:0] O_MRD   = {1'b1, 23'b0} | {20'b0, A_ADD, 1'b0};
  localparam logic [23:0] O_MWR   = {1'b1, 14'b0, 1'b1, 8'b0} | {20'b0, A_ADD, 1'b0};
  localparam logic [23:0] O_MWB   = {8'b0, 2'd1, 4'b0, 3'b0, 1'b1, 6'b0} | {20'b0, A_ADD, 1'b0};
  localparam logic [23:0] O_AWB   = {6'b0, 2'd1, 6'b0, 3'b0, 1'b1, 6'b0} | {20'b0, A_ADD, 1'b0};
  localparam logic [23:0] O_IWB   = {17'b0, 1'b1, 6'b0} | {20'b0, A_ADD, 1'b0};
  localparam logic [23:0] O_JMP   = {10'b0, 2'd2, 2'b0, 2'b0, 1'b1, 1'b0, 1'b1, 5'b0} | {20'b0, A_ADD, 1'b0};
  localparam logic [23:0] O_JAL   = {6'b0, 2'd2, 2'd2, 2'd2, 2'b0, 2'b0, 1'b1, 1'b1, 1'b1, 5'b0} | {20'b0, A_ADD, 1'b0};
  localparam logic [23:0] O_TRAP  = {20'b0, A_ADD, 1'b1};

  // ---------------- driver tasks ----------------
  task automatic cyc(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [3:0] st,
                     input logic [23:0] o);
    bus.Opcode   = opc;
    bus.Funct    = fn;
    bus.Zero     = z;
    bus.MemReady = mr;
    exp_q.push_back({st, o, cnt_exp});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                       input logic z, input int stalls);
    for (int i = 0; i < stalls; i++) cyc({tag, "_fstall"}, opc, fn, z, 0, S_F, o_fetch(0));
    cyc({tag, "_fetch"}, opc, fn, z, 1, S_F, o_fetch(1));
    cyc({tag, "_decode"}, opc, fn, z, 1, S_D, O_DEC);
  endtask

  task automatic t_lw(input int fst, input int rst_stall);
    fetch("lw", OP_LW, 0, 0, fst);
    cyc("lw_memadr", OP_LW, 0, 0, 1, S_A, O_MADR);
    for (int i = 0; i < rst_stall; i++) cyc("lw_rdstall", OP_LW, 0, 0, 0, S_R, O_MRD);
    cyc("lw_memread", OP_LW, 0, 0, 1, S_R, O_MRD);
    cyc("lw_memwb", OP_LW, 0, 0, 1, S_MWB, O_MWB);
    cnt_exp++;
  endtask

  task automatic t_sw(input int wst);
    fetch("sw", OP_SW, 0, 0, 0);
    cyc("sw_memadr", OP_SW, 0, 0, 1, S_A, O_MADR);
    for (int i = 0; i < wst; i++) cyc("sw_wrstall", OP_SW, 0, 0, 0, S_W, O_MWR);
    cyc("sw_memwrite", OP_SW, 0, 0, 1, S_W, O_MWR);
    cnt_exp++;
  endtask

  task automatic t_r(input logic [5:0] fn, input logic [3:0] a, input int fst);
    fetch("rtype", OP_R, fn, 0, fst);
    cyc("rtype_execute", OP_R, fn, 0, 1, S_E, o_exec(a));
    cyc("rtype_aluwb", OP_R, fn, 0, 1, S_AWB, O_AWB);
    cnt_exp++;
  endtask

  task automatic t_br(input logic [5:0] opc, input logic z, input logic [1:0] br,
                      input logic pcen);
    fetch("branch", opc, 0, z, 0);
    cyc("branch_exec", opc, 0, z, 1, S_B, o_branch(br, pcen));
    cnt_exp++;
  endtask

  task automatic t_i(input logic [5:0] opc, input logic [2:0] sb, input logic [3:0] a);
    fetch("itype", opc, 0, 0, 0);
    cyc("itype_iexec", opc, 0, 0, 1, S_IE, o_iexec(sb, a));
    cyc("itype_iwb", opc, 0, 0, 1, S_IWB, O_IWB);
    cnt_exp++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.Opcode = OP_R; bus.Funct = FN_ADD; bus.Zero = 1'b0; bus.MemReady = 1'b1;
    #3;
    chk("reset_state", 32'(state_dbg), 32'(S_F));
    chk("reset_cnt", 32'(bus.InstrCount), 0);
    chk("reset_irwrite_blocked", 32'(bus.IRWrite), 0);
    chk("reset_pcen_blocked", 32'(bus.PCEn), 0);
    chk("reset_srcb_fetch", 32'(bus.ALUSrcB), 32'b001);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    t_lw(0, 0);                           // 5-cycle LW, count 0 -> 1
    t_sw(3);                              // MemWrite held 4 cycles
    t_r(FN_ADD, A_ADD, 2);                // fetch stalled 2 cycles
    t_r(FN_SUB, A_SUB, 0);
    t_r(FN_NOR, A_NOR, 0);
    t_r(FN_XOR, A_XOR, 0);
    t_r(FN_BAD, A_ADD, 0);                // unknown funct decodes as add
    t_br(OP_BNE, 0, 2'b10, 1);
    t_br(OP_BNE, 1, 2'b10, 0);
    t_br(OP_BEQ, 1, 2'b01, 1);
    t_br(OP_BEQ, 0, 2'b01, 0);
    t_i(OP_ORI,  3'b100, A_OR);
    t_i(OP_ANDI, 3'b100, A_AND);
    t_i(OP_ADDI, 3'b010, A_ADD);
    t_i(OP_SLTI, 3'b010, A_SLT);
    fetch("j", OP_J, 0, 0, 0);
    cyc("j_jump", OP_J, 0, 0, 1, S_J, O_JMP);
    cnt_exp++;
    fetch("jal", OP_JAL, 0, 0, 0);
    cyc("jal_jal", OP_JAL, 0, 0, 1, S_JAL, O_JAL);
    cnt_exp++;
    t_lw(1, 1);                           // one fetch and one read stall

    // store interrupted by reset while waiting in MEMWRITE
    fetch("swrst", OP_SW, 0, 0, 0);
    cyc("swrst_memadr", OP_SW, 0, 0, 1, S_A, O_MADR);
    cyc("swrst_wrstall", OP_SW, 0, 0, 0, S_W, O_MWR);
    chk("swrst_memwrite_before", 32'(bus.MemWrite), 1);
    #2 rst = 1'b1;
    #1;
    chk("swrst_state", 32'(state_dbg), 32'(S_F));
    chk("swrst_memwrite_dropped", 32'(bus.MemWrite), 0);
    chk("swrst_regwrite", 32'(bus.RegWrite), 0);
    chk("swrst_cnt", 32'(bus.InstrCount), 0);
    cnt_exp = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // 17 retirements on a 4-bit counter wrap to 1
    for (int i = 0; i < 17; i++) t_r(FN_ADD, A_ADD, 0);
    chk("wrap_cnt", 32'(bus.InstrCount), 1);

    // illegal opcode: trap is held until reset
    fetch("trap", OP_BAD, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc("trap_hold", OP_BAD, 0, 0, 1, S_T, O_TRAP);
    #2 rst = 1'b1;
    #1;
    chk("traprst_state", 32'(state_dbg), 32'(S_F));
    chk("traprst_illegal", 32'(bus.IllegalInstr), 0);
    chk("traprst_cnt", 32'(bus.InstrCount), 0);
    chk("traprst_irwrite", 32'(bus.IRWrite), 0);
    chk("traprst_pcwrite", 32'(bus.PCWrite), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_exp = '0;
    t_br(OP_BEQ, 1, 2'b01, 1);            // back in service after the trap

    @(posedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Parametrised next-generation control unit for the multicycle MIPS datapath. It provides Moore-style main control with a memory-ready handshake that stalls fetch and data access, and zero-extended logical immediates (ANDI/ORI). It also adds JAL, BNE, an illegal-opcode trap state and a retired-instruction counter. It sits between the instruction register and the datapath muxes/enables, replacing the earlier fixed-latency controller.

## Interface
- OPCODE_WIDTH, 6, opcode field width
- FUNCT_WIDTH, 6, funct field width
- ALU_OP_WIDTH, 4, ALUControl width
- MEM_WAIT_EN, 1, 1: honour MemReady; 0: MemReady treated as constant 1
- CNT_WIDTH, 32, retired-instruction counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Opcode  in  OPCODE_WIDTH  IR[31:26]
- Funct  in  FUNCT_WIDTH  IR[5:0]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- IorD  out  1  0 = PC address, 1 = ALUOut
- ALUSrcA  out  2  0 = PC, 1 = A
- ALUSrcB  out  3  000 = B, 001 = 4, 010 = SignImm, 011 = SignImm<<2, 100 = ZeroImm
- RegDst  out  2  0 = rt, 1 = rd, 2 = r31
- MemtoReg  out  2  0 = ALUOut, 1 = Data, 2 = PC
- PCSrc  out  2  0 = ALUResult, 1 = ALUOut, 2 = jump target
- Branch  out  2  01 = BEQ, 10 = BNE, 00 = none
- IRWrite, MemWrite, PCWrite, RegWrite  out  1 each  enables
- PCEn  out  1  PCWrite | (Branch==01 & Zero) | (Branch==10 & ~Zero)
- ALUControl  out  ALU_OP_WIDTH  ALU operation code
- IllegalInstr  out  1  high while in TRAP
- InstrCount  out  CNT_WIDTH  retired instructions

## Operation
- States and transitions:
  - FETCH → DECODE when MemReady; otherwise stay in FETCH.
  - DECODE branches on Opcode:
    - LW/SW → MEMADR
    - R-type → EXECUTE
    - BEQ/BNE → BRANCH
    - ADDI/ANDI/ORI/SLTI → IEXEC
    - J → JUMP
    - JAL → JAL
    - anything else → TRAP
  - MEMADR → MEMREAD (LW) or MEMWRITE (SW).
  - MEMREAD → MEMWB on MemReady.
  - MEMWRITE → FETCH on MemReady.
  - EXECUTE → ALUWB.
  - IEXEC → IWB.
  - MEMWB, ALUWB, IWB, BRANCH, JUMP, JAL → FETCH.
  - TRAP is absorbing; only rst leaves it.
- Outputs per state (every unlisted output is 0; ALUOp defaults to add):
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=001, PCSrc=0, add; IRWrite=PCWrite=MemReady.
  - DECODE: ALUSrcA=0, ALUSrcB=011, add.
  - MEMADR: ALUSrcA=1, ALUSrcB=010, add.
  - MEMREAD: IorD=1.
  - MEMWRITE: IorD=1, MemWrite=1, held until MemReady.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=000, ALUOp=funct.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=000, sub, PCSrc=1; Branch=01 for BEQ, 10 for BNE.
  - IEXEC: ALUSrcA=1; ALUSrcB=100 for ANDI/ORI, else 010; ALUOp = add/and/or/slt by opcode.
  - IWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - JUMP: PCSrc=2, PCWrite=1.
  - JAL: PCSrc=2, PCWrite=1, RegDst=2, MemtoReg=2, RegWrite=1.
- ALU decoder mapping:
  - ALUOp: 000 add, 001 sub, 010 decode by Funct, 011 and, 100 or, 101 slt.
  - Funct mapping: ADD/ADDU → add, SUB/SUBU → sub, AND, OR, XOR, NOR, SLT; unknown Funct → add.
- InstrCount increments by 1 on each transition into FETCH from any state except FETCH. It wraps modulo 2^CNT_WIDTH.

## Timing
- State register updates on the rising edge of clk. Outputs are combinational from the state register plus Opcode/Funct/Zero/MemReady; there is no added pipeline latency.
- rst asserted at any time:
  - state ← FETCH and InstrCount ← 0, immediately (asynchronous).
  - All enable outputs (IRWrite, MemWrite, PCWrite, RegWrite, PCEn) are forced to 0 while rst is high.
  - Mux selects take their FETCH values; IllegalInstr = 0.
- Reset asserted mid-access (MEMWRITE): MemWrite drops in the same cycle and no writeback occurs.
- Instruction latencies with MemReady tied high:
  - LW: 5 cycles
  - SW, R-type, I-type ALU: 4 cycles
  - BEQ/BNE, J, JAL: 3 cycles
- Each cycle with MemReady low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- MEM_WAIT_EN=0: stalls never occur.

## Structure
- Shared defines: opcode, funct and ALU code constants, plus state encodings (4-bit, extended control_state_defines).
- Sub-module: mc_alu_decoder, parametrised by FUNCT_WIDTH and ALU_OP_WIDTH. It takes ALUOp[2:0] and Funct and produces ALUControl.
- The FSM, output decode, PCEn logic and counter live in the top module.

## Test plan
- LW, MemReady=1 → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and MemtoReg=1 in cycle 5; InstrCount 0→1.
- SW with MemReady low for 3 cycles in MEMWRITE → MemWrite high for 4 cycles; return to FETCH on cycle 8.
- BNE with Zero=0 → PCEn=1 in BRANCH; with Zero=1 → PCEn=0; PCSrc=1 in both cases.
- ORI → ALUSrcB=100 in IEXEC, ALUControl=or; JAL → RegDst=2, MemtoReg=2, PCSrc=2, RegWrite=PCWrite=1.
- Opcode 6'h3F → TRAP with IllegalInstr=1 held for 10 cycles. Async rst pulse mid-cycle → FETCH with IllegalInstr=0 and InstrCount=0 before the next edge.
- CNT_WIDTH=4, run 17 R-type instructions → InstrCount=1 (wrap).
